sdram_init_checker: RTL and testbench

//  Device-side receiver for the SDRAM init command bus: decodes {CS#,RAS#,CAS#,WE#}/addr/bank, checks the

---
 rtl/sdram_init_pkg.sv | 65 ++++++
 rtl/sdram_gap_timer.sv | 54 +++++
 rtl/sdram_init_checker.sv | 181 ++++++++++++++++++
 tb/tb_sdram_init_checker.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_init_pkg.sv
// Shared definitions for the SDRAM power-up sequence checker.
//  - command encodings on {CS#,RAS#,CAS#,WE#}
//  - err_code values reported by sdram_init_checker
//  - FSM state and decoded command kinds
//  - helpers for command decode and mode-register field checking
package sdram_init_pkg;

  localparam logic [3:0] CmdNop = 4'b0111;
  localparam logic [3:0] CmdPre = 4'b0010;
  localparam logic [3:0] CmdAr  = 4'b0001;
  localparam logic [3:0] CmdMrs = 4'b0000;

  localparam logic [2:0] ErrNone    = 3'd0;
  localparam logic [2:0] ErrEarly   = 3'd1;
  localparam logic [2:0] ErrTrp     = 3'd2;
  localparam logic [2:0] ErrTrfc    = 3'd3;
  localparam logic [2:0] ErrTmrd    = 3'd4;
  localparam logic [2:0] ErrSeq     = 3'd5;
  localparam logic [2:0] ErrArCnt   = 3'd6;
  localparam logic [2:0] ErrBadMode = 3'd7;

  typedef enum logic [2:0] {
    StPwrup,
    StTrp,
    StTrfc,
    StTmrd,
    StReady,
    StError
  } init_state_e;

  typedef enum logic [2:0] {
    KindNop,
    KindPre,
    KindAr,
    KindMrs,
    KindIllegal
  } cmd_kind_e;

  // Deselect (CS#=1) is a NOP regardless of the other three lines.
  function automatic cmd_kind_e decode_cmd(input logic [3:0] cmd);
    cmd_kind_e kind;
    if (cmd[3] || (cmd == CmdNop)) begin
      kind = KindNop;
    end else if (cmd == CmdPre) begin
      kind = KindPre;
    end else if (cmd == CmdAr) begin
      kind = KindAr;
    end else if (cmd == CmdMrs) begin
      kind = KindMrs;
    end else begin
      kind = KindIllegal;
    end
    return kind;
  endfunction

  // CAS latency 2 or 3, burst 1/2/4/8/page, standard operating mode.
  function automatic logic mode_fields_ok(input logic [12:0] a);
    logic cl_ok;
    logic bl_ok;
    cl_ok = (a[6:4] == 3'b010) || (a[6:4] == 3'b011);
    bl_ok = (a[2:0] <= 3'b011) || (a[2:0] == 3'b111);
    return cl_ok && bl_ok && (a[8:7] == 2'b00);
  endfunction

endpackage

// File: rtl/sdram_gap_timer.sv
// Power-up and inter-command timers for the SDRAM init checker.
// Ports:
//  init_clk, init_rst_n : clock, asynchronous active-low reset
//  cmd_seen             : current edge samples a non-NOP command
//  pwr_ok               : power-up wait of T_WAIT cycles has elapsed
//  gap_cnt              : cycles since the last non-NOP, saturating at 31
module sdram_gap_timer #(
  parameter int unsigned T_WAIT = 10000
) (
  input  logic       init_clk,
  input  logic       init_rst_n,
  input  logic       cmd_seen,
  output logic       pwr_ok,
  output logic [4:0] gap_cnt
);

  localparam int unsigned PwrW = (T_WAIT < 1) ? 1 : $clog2(T_WAIT + 1);
  localparam logic [PwrW-1:0] PwrMax = PwrW'(T_WAIT);

  logic [PwrW-1:0] pwr_cnt_q, pwr_cnt_d;
  logic [4:0]      gap_cnt_q, gap_cnt_d;

  always_comb begin
    pwr_cnt_d = pwr_cnt_q;
    if (pwr_cnt_q != PwrMax) begin
      pwr_cnt_d = pwr_cnt_q + PwrW'(1);
    end
  end

  // Loading 1 on the command edge makes gap_cnt equal the edge distance
  // to the previous command when the next one is sampled.
  always_comb begin
    gap_cnt_d = gap_cnt_q;
    if (cmd_seen) begin
      gap_cnt_d = 5'd1;
    end else if (gap_cnt_q != 5'd31) begin
      gap_cnt_d = gap_cnt_q + 5'd1;
    end
  end

  always_ff @(posedge init_clk or negedge init_rst_n) begin
    if (!init_rst_n) begin
      pwr_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      pwr_cnt_q <= pwr_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  assign pwr_ok  = (pwr_cnt_q == PwrMax);
  assign gap_cnt = gap_cnt_q;

endmodule

// File: rtl/sdram_init_checker.sv
// Device-side checker for the SDRAM power-up command sequence:
// wait T_WAIT, PRECHARGE-all, >= AR_MIN AUTO REFRESH, MRS, then READY after TMRD.
// Enforces tRP/tRFC/tMRD spacing and records the first violation.
// Optional macro SDRAM_INIT_CHK_MODE_EN: accepted MRS must also carry a supported
// CAS latency / burst length / operating mode, else err_code 7 (mode_reg still latched).
// Ports:
//  init_clk, init_rst_n : clock, asynchronous active-low reset
//  cmd                  : {CS#,RAS#,CAS#,WE#}
//  addr, bank           : SDRAM address and bank address
//  init_done            : sequence complete (READY)
//  init_err             : sticky error flag
//  err_code             : first error cause
//  mode_reg             : address captured on the accepted MRS
//  ar_cnt               : accepted AUTO REFRESH count, saturating at 15
module sdram_init_checker
  import sdram_init_pkg::*;
#(
  parameter int unsigned T_WAIT = 10000,
  parameter int unsigned TRP    = 2,
  parameter int unsigned TRFC   = 8,
  parameter int unsigned TMRD   = 3,
  parameter int unsigned AR_MIN = 2
) (
  input  logic        init_clk,
  input  logic        init_rst_n,
  input  logic [3:0]  cmd,
  input  logic [12:0] addr,
  input  logic [1:0]  bank,
  output logic        init_done,
  output logic        init_err,
  output logic [2:0]  err_code,
  output logic [12:0] mode_reg,
  output logic [3:0]  ar_cnt
);

  localparam logic [4:0] TrpGap  = 5'(TRP);
  localparam logic [4:0] TrfcGap = 5'(TRFC);
  localparam logic [4:0] TmrdGap = 5'(TMRD);
  localparam logic [3:0] ArMin   = 4'(AR_MIN);

  init_state_e state_q, state_d;
  cmd_kind_e   cmd_kind;
  logic        cmd_seen;
  logic        pwr_ok;
  logic [4:0]  gap_cnt;

  logic        init_done_q, init_done_d;
  logic        init_err_q, init_err_d;
  logic [2:0]  err_code_q, err_code_d;
  logic [12:0] mode_reg_q, mode_reg_d;
  logic [3:0]  ar_cnt_q, ar_cnt_d;
  logic [3:0]  ar_cnt_inc;

  assign cmd_kind   = decode_cmd(cmd);
  assign cmd_seen   = (cmd_kind != KindNop);
  assign ar_cnt_inc = (ar_cnt_q == 4'd15) ? ar_cnt_q : ar_cnt_q + 4'd1;

  sdram_gap_timer #(
    .T_WAIT(T_WAIT)
  ) u_gap_timer (
    .init_clk  (init_clk),
    .init_rst_n(init_rst_n),
    .cmd_seen  (cmd_seen),
    .pwr_ok    (pwr_ok),
    .gap_cnt   (gap_cnt)
  );

  // Within each state the spacing check comes before the sequence check.
  always_comb begin
    state_d    = state_q;
    err_code_d = err_code_q;
    mode_reg_d = mode_reg_q;
    ar_cnt_d   = ar_cnt_q;

    unique case (state_q)
      StPwrup: begin
        if (cmd_seen) begin
          if (!pwr_ok) begin
            state_d    = StError;
            err_code_d = ErrEarly;
          end else if ((cmd_kind == KindPre) && addr[10]) begin
            state_d = StTrp;
          end else begin
            state_d    = StError;
            err_code_d = ErrSeq;
          end
        end
      end

      StTrp: begin
        if (cmd_seen) begin
          if (gap_cnt < TrpGap) begin
            state_d    = StError;
            err_code_d = ErrTrp;
          end else if (cmd_kind == KindAr) begin
            state_d  = StTrfc;
            ar_cnt_d = ar_cnt_inc;
          end else begin
            state_d    = StError;
            err_code_d = ErrSeq;
          end
        end
      end

      StTrfc: begin
        if (cmd_seen) begin
          if (gap_cnt < TrfcGap) begin
            state_d    = StError;
            err_code_d = ErrTrfc;
          end else if (cmd_kind == KindAr) begin
            ar_cnt_d = ar_cnt_inc;
          end else if ((cmd_kind == KindMrs) && (ar_cnt_q < ArMin)) begin
            state_d    = StError;
            err_code_d = ErrArCnt;
          end else if ((cmd_kind == KindMrs) && (bank == 2'b00)) begin
            mode_reg_d = addr;
`ifdef SDRAM_INIT_CHK_MODE_EN
            if (!mode_fields_ok(addr)) begin
              state_d    = StError;
              err_code_d = ErrBadMode;
            end else begin
              state_d = StTmrd;
            end
`else
            state_d = StTmrd;
`endif
          end else begin
            state_d    = StError;
            err_code_d = ErrSeq;
          end
        end
      end

      StTmrd: begin
        if (cmd_seen && (gap_cnt < TmrdGap)) begin
          state_d    = StError;
          err_code_d = ErrTmrd;
        end else if (gap_cnt >= TmrdGap) begin
          // Only gap_cnt == TMRD is reachable here: READY exactly TMRD edges after MRS.
          state_d = StReady;
        end
      end

      StReady, StError: begin
        state_d = state_q;
      end

      default: begin
        state_d = StPwrup;
      end
    endcase

    init_done_d = (state_d == StReady);
    init_err_d  = (state_d == StError);
  end

  always_ff @(posedge init_clk or negedge init_rst_n) begin
    if (!init_rst_n) begin
      state_q     <= StPwrup;
      init_done_q <= 1'b0;
      init_err_q  <= 1'b0;
      err_code_q  <= ErrNone;
      mode_reg_q  <= '0;
      ar_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      init_done_q <= init_done_d;
      init_err_q  <= init_err_d;
      err_code_q  <= err_code_d;
      mode_reg_q  <= mode_reg_d;
      ar_cnt_q    <= ar_cnt_d;
    end
  end

  assign init_done = init_done_q;
  assign init_err  = init_err_q;
  assign err_code  = err_code_q;
  assign mode_reg  = mode_reg_q;
  assign ar_cnt    = ar_cnt_q;

endmodule

// File: tb/tb_sdram_init_checker.sv
// Bench for sdram_init_checker with T_WAIT=20. Each scenario is a list of
// (edge, command) events; edge 1 is the first rising edge after reset release.
// A sequence-level model walks the event list and predicts the final outputs
// and the edges on which init_err / init_done first rise.
module tb_sdram_init_checker;

  localparam int T_WAIT = 20;
  localparam int TRP    = 2;
  localparam int TRFC   = 8;
  localparam int TMRD   = 3;
  localparam int AR_MIN = 2;

  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_AR  = 4'b0001;
  localparam logic [3:0] C_MRS = 4'b0000;
  localparam logic [3:0] C_ACT = 4'b0011;

  typedef struct {
    int          cyc;
    logic [3:0]  cmd;
    logic [12:0] addr;
    logic [1:0]  bank;
  } ev_t;

  logic        init_clk = 1'b0;
  logic        init_rst_n = 1'b1;
  logic [3:0]  cmd = 4'b0111;
  logic [12:0] addr = '0;
  logic [1:0]  bank = '0;
  logic        init_done;
  logic        init_err;
  logic [2:0]  err_code;
  logic [12:0] mode_reg;
  logic [3:0]  ar_cnt;

  int errors = 0;
  int checks = 0;

  ev_t         evq[$];
  int          exp_err_edge, exp_done_edge, obs_err_edge, obs_done_edge;
  logic [2:0]  exp_code;
  logic [12:0] exp_mode;
  logic [3:0]  exp_ar;

  sdram_init_checker #(
    .T_WAIT(T_WAIT)
  ) dut (
    .init_clk  (init_clk),
    .init_rst_n(init_rst_n),
    .cmd       (cmd),
    .addr      (addr),
    .bank      (bank),
    .init_done (init_done),
    .init_err  (init_err),
    .err_code  (err_code),
    .mode_reg  (mode_reg),
    .ar_cnt    (ar_cnt)
  );

  always #5 init_clk = ~init_clk;

  function automatic int kind_of(input logic [3:0] c);
    if (c[3] || c == 4'b0111) return 0;
    if (c == C_PRE) return 1;
    if (c == C_AR) return 2;
    if (c == C_MRS) return 3;
    return 4;
  endfunction

  task automatic add_ev(input int c, input logic [3:0] k, input logic [12:0] a, input logic [1:0] b);
    ev_t e;
    e.cyc = c; e.cmd = k; e.addr = a; e.bank = b;
    evq.push_back(e);
  endtask

  // Sequence model: phase 0 wait PRE, 1 wait first AR, 2 refreshing, 3 after MRS, 9 error.
  task automatic predict();
    int phase, last, mrs_c, gap, c, k;
    logic [12:0] a;
    logic mode_ok;
    exp_err_edge = -1; exp_done_edge = -1; exp_code = 0; exp_mode = 0; exp_ar = 0;
    phase = 0; last = 0; mrs_c = 0;
    for (int i = 0; i < evq.size(); i++) begin
      c = evq[i].cyc; k = kind_of(evq[i].cmd); a = evq[i].addr;
      if (phase == 9) break;
      if (phase == 3 && c - mrs_c >= TMRD) break;
      gap = (c - last > 31) ? 31 : c - last;
      last = c;
      case (phase)
        0: begin
          if (c - 1 < T_WAIT) begin phase = 9; exp_code = 1; exp_err_edge = c; end
          else if (k == 1 && a[10]) phase = 1;
          else begin phase = 9; exp_code = 5; exp_err_edge = c; end
        end
        1: begin
          if (gap < TRP) begin phase = 9; exp_code = 2; exp_err_edge = c; end
          else if (k == 2) begin phase = 2; exp_ar = 1; end
          else begin phase = 9; exp_code = 5; exp_err_edge = c; end
        end
        2: begin
          if (gap < TRFC) begin phase = 9; exp_code = 3; exp_err_edge = c; end
          else if (k == 2) begin if (exp_ar != 15) exp_ar = exp_ar + 1; end
          else if (k == 3 && exp_ar < AR_MIN) begin phase = 9; exp_code = 6; exp_err_edge = c; end
          else if (k == 3 && evq[i].bank == 0) begin
            exp_mode = a;
            mode_ok = ((a[6:4] == 3'b010) || (a[6:4] == 3'b011)) &&
                      (a[2:0] inside {3'b000, 3'b001, 3'b010, 3'b011, 3'b111}) && (a[8:7] == 2'b00);
`ifdef SDRAM_INIT_CHK_MODE_EN
            if (!mode_ok) begin phase = 9; exp_code = 7; exp_err_edge = c; end
            else begin phase = 3; mrs_c = c; end
`else
            if (mode_ok || !mode_ok) begin phase = 3; mrs_c = c; end
`endif
          end
          else begin phase = 9; exp_code = 5; exp_err_edge = c; end
        end
        default: begin phase = 9; exp_code = 4; exp_err_edge = c; end
      endcase
    end
    if (phase == 3) exp_done_edge = mrs_c + TMRD;
  endtask

  // Reset, then drive n edges; gaps between events carry random NOP/deselect patterns.
  task automatic drive_seq(input int n);
    bit found;
    init_rst_n = 1'b0;
    cmd = 4'b0111;
    repeat (3) @(posedge init_clk);
    @(negedge init_clk);
    init_rst_n = 1'b1;
    obs_err_edge = -1; obs_done_edge = -1;
    for (int k = 1; k <= n; k++) begin
      found = 0;
      for (int i = 0; i < evq.size(); i++) begin
        if (evq[i].cyc == k) begin
          cmd = evq[i].cmd; addr = evq[i].addr; bank = evq[i].bank; found = 1;
        end
      end
      if (!found) begin
        cmd  = ($urandom_range(0, 1) == 1) ? 4'b0111 : {1'b1, 3'($urandom)};
        addr = 13'($urandom);
        bank = 2'($urandom);
      end
      @(posedge init_clk);
      #1;
      if (init_done === 1'b1 && obs_done_edge < 0) obs_done_edge = k;
      if (init_err === 1'b1 && obs_err_edge < 0) obs_err_edge = k;
      @(negedge init_clk);
    end
  endtask

  function automatic int run_len();
    return evq[evq.size()-1].cyc + 10;
  endfunction

  task automatic build(input int id);
    evq.delete();
    if (id != 2 && id != 3 && id != 13) add_ev(21, C_PRE, (id == 8) ? 13'h000 : 13'h400, 2'b00);
    case (id)
      1: begin
        add_ev(24, C_AR, 13'h0, 0); add_ev(33, C_AR, 13'h0, 0); add_ev(42, C_MRS, 13'h037, 0);
        add_ev(50, C_AR, 13'h0, 0); add_ev(55, C_ACT, 13'h0, 0); add_ev(60, C_PRE, 13'h0, 0);
      end
      2: add_ev(15, C_PRE, 13'h400, 0);
      3: add_ev(20, C_PRE, 13'h400, 0);
      4: add_ev(22, C_AR, 13'h0, 0);
      5: begin add_ev(23, C_AR, 13'h0, 0); add_ev(31, C_AR, 13'h0, 0); add_ev(39, C_MRS, 13'h022, 0); end
      6: begin add_ev(24, C_AR, 13'h0, 0); add_ev(26, C_AR, 13'h0, 0); end
      7: begin add_ev(24, C_AR, 13'h0, 0); add_ev(33, C_MRS, 13'h037, 0); end
      8: add_ev(24, C_AR, 13'h0, 0);
      9: begin add_ev(24, C_AR, 13'h0, 0); add_ev(33, C_ACT, 13'h0, 0); end
      10: begin
        add_ev(24, C_AR, 13'h0, 0); add_ev(33, C_AR, 13'h0, 0);
        add_ev(42, C_MRS, 13'h037, 0); add_ev(43, C_PRE, 13'h400, 0);
      end
      11: begin add_ev(24, C_AR, 13'h0, 0); add_ev(33, C_AR, 13'h0, 0); add_ev(42, C_MRS, 13'h047, 0); end
      12: begin add_ev(24, C_AR, 13'h0, 0); add_ev(33, C_AR, 13'h0, 0); add_ev(42, C_MRS, 13'h037, 1); end
      default: add_ev(25, C_MRS, 13'h037, 0);
    endcase
  endtask

  task automatic build_random();
    logic [3:0]  ill [4] = '{4'b0011, 4'b0101, 4'b0100, 4'b0110};
    logic [3:0]  pick [4] = '{C_PRE, C_AR, C_MRS, 4'b0011};
    logic [12:0] a;
    int c, bl;
    evq.delete();
    c = $urandom_range(T_WAIT - 3, T_WAIT + 4);
    a = 13'($urandom);
    a[10] = ($urandom_range(0, 9) != 0);
    add_ev(c, C_PRE, a, 2'($urandom));
    for (int j = 0; j < int'($urandom_range(1, 4)); j++) begin
      c += (j == 0) ? $urandom_range(TRP - 1, TRP + 3) : $urandom_range(TRFC - 1, TRFC + 3);
      add_ev(c, ($urandom_range(0, 15) == 0) ? ill[$urandom_range(0, 3)] : C_AR, 13'($urandom), 0);
    end
    c += $urandom_range(TRFC - 1, TRFC + 3);
    a = 13'($urandom);
    if ($urandom_range(0, 3) != 0) begin
      a[8:7] = 2'b00;
      a[6:4] = {2'b01, 1'($urandom)};
      bl = $urandom_range(0, 4);
      a[2:0] = (bl == 4) ? 3'b111 : 3'(bl);
    end
    add_ev(c, C_MRS, a, ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00);
    if ($urandom_range(0, 1) == 1) add_ev(c + $urandom_range(1, 5), pick[$urandom_range(0, 3)], 13'($urandom), 0);
  endtask

  task automatic test_reset();
    #1 init_rst_n = 1'b0;
    cmd = C_PRE; addr = 13'h1fff; bank = 2'b11;
    repeat (2) @(posedge init_clk);
    #1;
    checks += 5;
    if (init_done !== 1'b0) begin errors++; $display("FAIL reset init_done: got %b want 0", init_done); end
    if (init_err !== 1'b0) begin errors++; $display("FAIL reset init_err: got %b want 0", init_err); end
    if (err_code !== 3'd0) begin errors++; $display("FAIL reset err_code: got %0d want 0", err_code); end
    if (mode_reg !== 13'd0) begin errors++; $display("FAIL reset mode_reg: got %h want 0", mode_reg); end
    if (ar_cnt !== 4'd0) begin errors++; $display("FAIL reset ar_cnt: got %0d want 0", ar_cnt); end
  endtask

  // Directed scenarios: id 1 is the legal flow, the rest exercise each error cause and boundary.
  task automatic test_directed(input int first, input int last_id);
    string nm;
    for (int id = first; id <= last_id; id++) begin
      nm = $sformatf("dir%0d", id);
      build(id);
      predict();
      drive_seq(run_len());
      checks += 7;
      if (obs_err_edge != exp_err_edge) begin errors++; $display("FAIL %s err_edge: got %0d want %0d", nm, obs_err_edge, exp_err_edge); end
      if (obs_done_edge != exp_done_edge) begin errors++; $display("FAIL %s done_edge: got %0d want %0d", nm, obs_done_edge, exp_done_edge); end
      if (init_err !== (exp_err_edge >= 0)) begin errors++; $display("FAIL %s init_err: got %b want %b", nm, init_err, exp_err_edge >= 0); end
      if (init_done !== (exp_done_edge >= 0)) begin errors++; $display("FAIL %s init_done: got %b want %b", nm, init_done, exp_done_edge >= 0); end
      if (err_code !== exp_code) begin errors++; $display("FAIL %s err_code: got %0d want %0d", nm, err_code, exp_code); end
      if (mode_reg !== exp_mode) begin errors++; $display("FAIL %s mode_reg: got %h want %h", nm, mode_reg, exp_mode); end
      if (ar_cnt !== exp_ar) begin errors++; $display("FAIL %s ar_cnt: got %0d want %0d", nm, ar_cnt, exp_ar); end
    end
  endtask

  task automatic test_reset_midseq();
    build(1);
    drive_seq(30);
    checks += 2;
    if (ar_cnt !== 4'd1) begin errors++; $display("FAIL midseq pre ar_cnt: got %0d want 1", ar_cnt); end
    if (init_err !== 1'b0) begin errors++; $display("FAIL midseq pre init_err: got %b want 0", init_err); end
    #2 init_rst_n = 1'b0;
    #1;
    checks += 3;
    if (ar_cnt !== 4'd0) begin errors++; $display("FAIL midseq async ar_cnt: got %0d want 0", ar_cnt); end
    if (init_done !== 1'b0 || init_err !== 1'b0) begin errors++; $display("FAIL midseq async flags: got %b%b want 00", init_done, init_err); end
    if (err_code !== 3'd0 || mode_reg !== 13'd0) begin errors++; $display("FAIL midseq async regs: got %0d/%h want 0/0", err_code, mode_reg); end
    predict();
    drive_seq(run_len());
    checks += 3;
    if (obs_done_edge != exp_done_edge) begin errors++; $display("FAIL midseq done_edge: got %0d want %0d", obs_done_edge, exp_done_edge); end
    if (ar_cnt !== exp_ar) begin errors++; $display("FAIL midseq ar_cnt: got %0d want %0d", ar_cnt, exp_ar); end
    if (mode_reg !== exp_mode) begin errors++; $display("FAIL midseq mode_reg: got %h want %h", mode_reg, exp_mode); end
  endtask

  task automatic test_random(input int iters);
    for (int it = 0; it < iters; it++) begin
      build_random();
      predict();
      drive_seq(run_len());
      checks += 5;
      if (obs_err_edge != exp_err_edge) begin errors++; $display("FAIL rnd%0d err_edge: got %0d want %0d", it, obs_err_edge, exp_err_edge); end
      if (obs_done_edge != exp_done_edge) begin errors++; $display("FAIL rnd%0d done_edge: got %0d want %0d", it, obs_done_edge, exp_done_edge); end
      if (err_code !== exp_code) begin errors++; $display("FAIL rnd%0d err_code: got %0d want %0d", it, err_code, exp_code); end
      if (mode_reg !== exp_mode) begin errors++; $display("FAIL rnd%0d mode_reg: got %h want %h", it, mode_reg, exp_mode); end
      if (ar_cnt !== exp_ar) begin errors++; $display("FAIL rnd%0d ar_cnt: got %0d want %0d", it, ar_cnt, exp_ar); end
    end
  endtask

  initial begin
    test_reset();
    test_directed(1, 1);
    test_directed(2, 13);
    test_reset_midseq();
    test_random(25);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
